// File: rtl/usb_rx_frame_ctrl_pkg.sv
// Shared types for the USB receive frame controller.
// Holds FSM states, error causes and the PID width.
package usb_rx_pkg;

    localparam int PID_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PID   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PID     = 3'd1,
        ERR_RXERR   = 3'd2,
        ERR_OVF     = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_SHORT   = 3'd5
    } err_t;

    // Upper nibble of a PID byte must be the complement of the lower.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_frame_ctrl_if.sv
// UTMI receive side plus framed payload outputs.
// slave = frame controller, master = UTMI source / consumer.
interface usb_rx_frame_ctrl_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 1026
);
    import usb_rx_pkg::*;

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    logic              rx_active;
    logic              rx_valid;
    logic              rx_valid_h;
    logic              rx_error;
    logic [DATA_W-1:0] rx_data;

    logic [PID_W-1:0]  pid;
    logic              pid_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic [BE_W-1:0]   data_out_be;
    logic [CNT_W-1:0]  byte_count;
    logic              frame_complete;
    logic              error_flag;
    logic [2:0]        error_code;

    modport slave (
        input  rx_active, rx_valid, rx_valid_h, rx_error, rx_data,
        output pid, pid_valid, data_out, data_out_valid, data_out_be,
        output byte_count, frame_complete, error_flag, error_code
    );

    modport master (
        output rx_active, rx_valid, rx_valid_h, rx_error, rx_data,
        input  pid, pid_valid, data_out, data_out_valid, data_out_be,
        input  byte_count, frame_complete, error_flag, error_code
    );

endinterface

// File: rtl/usb_rx_frame_ctrl_gap_timer.sv
// Counts consecutive idle cycles inside a frame payload.
// expired fires on the GAP_TIMEOUT-th consecutive counted cycle.
module usb_rx_gap_timer #(
    parameter int GAP_TIMEOUT = 16
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = $clog2(GAP_TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    assign expired = count && (cnt_q == W'(GAP_TIMEOUT - 1));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/usb_rx_frame_ctrl.sv
// UTMI receive framer: PID check, payload forwarding, error capture.
// All outputs come straight from flops.
module usb_rx_frame_ctrl
    import usb_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MAX_BYTES   = 1026,
    parameter int GAP_TIMEOUT = 16
) (
    input logic                clk,
    input logic                nRST,
    usb_rx_frame_ctrl_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    state_t            state_q, state_d;
    err_t              err_q, err_d;
    logic              act_q;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic              pv_q, pv_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [BE_W-1:0]   beat_be, pid_be;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              flag_q;
    logic              hi;
    logic [CNT_W:0]    cnt_sum;
    logic              ovf;
    logic              gap_clear, gap_count, gap_expired;

    assign hi = (DATA_W == 16) && bus.rx_valid_h;

    always_comb begin
        beat_be         = '0;
        pid_be          = '0;
        beat_be[BE_W-1] = hi;
        pid_be[BE_W-1]  = hi;
        beat_be[0]      = 1'b1;
    end

    assign cnt_sum = {1'b0, cnt_q}
                   + (hi ? (CNT_W+1)'(2) : (CNT_W+1)'(1));
    assign ovf     = cnt_sum > (CNT_W+1)'(MAX_BYTES);

    assign gap_clear = (state_q != DATA) || bus.rx_valid;
    assign gap_count = (state_q == DATA) && bus.rx_active
                     && !bus.rx_valid;

    usb_rx_gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap (
        .clk    (clk),
        .nRST   (nRST),
        .clear  (gap_clear),
        .count  (gap_count),
        .expired(gap_expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        pid_d   = pid_q;
        pv_d    = 1'b0;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        be_d    = '0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_active && !act_q) begin
                    state_d = PID;
                    cnt_d   = '0;
                    err_d   = ERR_NONE;
                end
            end
            PID: begin
                if (!bus.rx_active) begin
                    err_d   = ERR_SHORT;
                    state_d = DONE;
                end else if (bus.rx_error) begin
                    err_d   = ERR_RXERR;
                    state_d = DRAIN;
                end else if (bus.rx_valid) begin
                    if (pid_ok(bus.rx_data[7:0])) begin
                        pid_d   = bus.rx_data[3:0];
                        pv_d    = 1'b1;
                        state_d = DATA;
                        // 16-bit PID beat may carry the first payload byte
                        if (hi) begin
                            dout_d = bus.rx_data;
                            dv_d   = 1'b1;
                            be_d   = pid_be;
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_d   = ERR_PID;
                        state_d = DRAIN;
                    end
                end
            end
            DATA: begin
                if (bus.rx_error) begin
                    err_d   = ERR_RXERR;
                    state_d = DRAIN;
                end else if (bus.rx_valid && ovf) begin
                    err_d   = ERR_OVF;
                    state_d = DRAIN;
                end else if (gap_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = DRAIN;
                end else if (!bus.rx_active) begin
                    state_d = DONE;
                end else if (bus.rx_valid) begin
                    dout_d = bus.rx_data;
                    dv_d   = 1'b1;
                    be_d   = beat_be;
                    cnt_d  = cnt_sum[CNT_W-1:0];
                end
            end
            DRAIN: begin
                if (!bus.rx_active) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            act_q   <= 1'b1;
            pid_q   <= '0;
            pv_q    <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            be_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            act_q   <= bus.rx_active;
            pid_q   <= pid_d;
            pv_q    <= pv_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            flag_q  <= (err_d != ERR_NONE);
        end
    end

    assign bus.pid            = pid_q;
    assign bus.pid_valid      = pv_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dv_q;
    assign bus.data_out_be    = be_q;
    assign bus.byte_count     = cnt_q;
    assign bus.frame_complete = done_q;
    assign bus.error_flag     = flag_q;
    assign bus.error_code     = err_q;

endmodule

// File: tb/tb_usb_rx_frame_ctrl.sv
// Directed bench: 8-bit framer (defaults) and 16-bit framer with
// MAX_BYTES=4, sharing clock and reset.
module tb_usb_rx_frame_ctrl;

    logic clk;
    logic nRST;

    int checks;
    int failures;

    logic [7:0]  dq8[$];
    logic [15:0] dq16[$];
    logic [1:0]  be16[$];
    int          npv8;
    int          nfc8;
    int          nfc16;

    usb_rx_frame_ctrl_if #(.DATA_W(8), .MAX_BYTES(1026)) if8 ();
    usb_rx_frame_ctrl_if #(.DATA_W(16), .MAX_BYTES(4)) if16 ();

    usb_rx_frame_ctrl #(
        .DATA_W(8), .MAX_BYTES(1026), .GAP_TIMEOUT(16)
    ) u8 (
        .clk(clk), .nRST(nRST), .bus(if8)
    );

    usb_rx_frame_ctrl #(
        .DATA_W(16), .MAX_BYTES(4), .GAP_TIMEOUT(16)
    ) u16 (
        .clk(clk), .nRST(nRST), .bus(if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if8.data_out_valid) dq8.push_back(if8.data_out);
        if (if8.pid_valid) npv8++;
        if (if8.frame_complete) nfc8++;
        if (if16.data_out_valid) begin
            dq16.push_back(if16.data_out);
            be16.push_back(if16.data_out_be);
        end
        if (if16.frame_complete) nfc16++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        dq8.delete();
        dq16.delete();
        be16.delete();
        npv8  = 0;
        nfc8  = 0;
        nfc16 = 0;
    endtask

    task automatic beat8(input logic [7:0] d);
        if8.rx_valid = 1'b1;
        if8.rx_data  = d;
        step();
        if8.rx_valid = 1'b0;
        if8.rx_data  = '0;
    endtask

    task automatic beat16(input logic [15:0] d, input logic h);
        if16.rx_valid   = 1'b1;
        if16.rx_valid_h = h;
        if16.rx_data    = d;
        step();
        if16.rx_valid   = 1'b0;
        if16.rx_valid_h = 1'b0;
        if16.rx_data    = '0;
    endtask

    task automatic test_reset();
        logic [32:0] o8;
        logic [42:0] o16;
        nRST = 1'b0;
        {if8.rx_active, if8.rx_valid, if8.rx_valid_h} = '0;
        if8.rx_error = 1'b0;
        if8.rx_data  = '0;
        {if16.rx_active, if16.rx_valid, if16.rx_valid_h} = '0;
        if16.rx_error = 1'b0;
        if16.rx_data  = '0;
        step();
        step();
        o8 = {if8.pid, if8.pid_valid, if8.data_out,
              if8.data_out_valid, if8.data_out_be, if8.byte_count,
              if8.frame_complete, if8.error_flag, if8.error_code};
        checks++;
        if (o8 !== '0) begin
            failures++;
            $display("FAIL reset_out8 got=%h exp=0", o8);
        end
        o16 = {if16.pid, if16.pid_valid, if16.data_out,
               if16.data_out_valid, if16.data_out_be,
               if16.byte_count, if16.frame_complete,
               if16.error_flag, if16.error_code};
        checks++;
        if (o16 !== '0) begin
            failures++;
            $display("FAIL reset_out16 got=%h exp=0", o16);
        end
        nRST = 1'b1;
        repeat (3) step();
        clr_mon();
    endtask

    task automatic test_good_frame();
        clr_mon();
        if8.rx_active = 1'b1;
        step();
        beat8(8'hC3);
        checks++;
        if (if8.pid_valid !== 1'b1 || if8.pid !== 4'h3) begin
            failures++;
            $display("FAIL good_pid got=%b/%h exp=1/3",
                     if8.pid_valid, if8.pid);
        end
        beat8(8'h11);
        checks++;
        if (if8.data_out_valid !== 1'b1 || if8.data_out !== 8'h11
            || if8.data_out_be !== 1'b1 || if8.byte_count !== 1) begin
            failures++;
            $display("FAIL good_beat1 got=%b %h %b %0d exp=1 11 1 1",
                     if8.data_out_valid, if8.data_out,
                     if8.data_out_be, if8.byte_count);
        end
        beat8(8'h22);
        beat8(8'h33);
        if8.rx_active = 1'b0;
        step();
        checks++;
        if (if8.frame_complete !== 1'b1 || if8.error_code !== 3'd0
            || if8.byte_count !== 3 || if8.error_flag !== 1'b0) begin
            failures++;
            $display("FAIL good_done got=%b %0d %0d %b exp=1 0 3 0",
                     if8.frame_complete, if8.error_code,
                     if8.byte_count, if8.error_flag);
        end
        step();
        step();
        checks++;
        if (if8.frame_complete !== 1'b0 || if8.byte_count !== 3
            || if8.pid !== 4'h3) begin
            failures++;
            $display("FAIL good_hold got=%b %0d %h exp=0 3 3",
                     if8.frame_complete, if8.byte_count, if8.pid);
        end
        checks++;
        if (dq8.size() !== 3 || npv8 !== 1 || nfc8 !== 1) begin
            failures++;
            $display("FAIL good_counts got=%0d %0d %0d exp=3 1 1",
                     dq8.size(), npv8, nfc8);
        end else begin
            checks++;
            if (dq8[0] !== 8'h11 || dq8[1] !== 8'h22
                || dq8[2] !== 8'h33) begin
                failures++;
                $display("FAIL good_order got=%h %h %h exp=11 22 33",
                         dq8[0], dq8[1], dq8[2]);
            end
        end
    endtask

    task automatic test_bad_pid();
        clr_mon();
        if8.rx_active = 1'b1;
        step();
        beat8(8'hC4);
        checks++;
        if (if8.error_code !== 3'd1 || if8.error_flag !== 1'b1
            || if8.pid_valid !== 1'b0) begin
            failures++;
            $display("FAIL badpid_err got=%0d %b %b exp=1 1 0",
                     if8.error_code, if8.error_flag, if8.pid_valid);
        end
        beat8(8'h55);
        beat8(8'h66);
        step();
        checks++;
        if (if8.frame_complete !== 1'b0) begin
            failures++;
            $display("FAIL badpid_drain got=%b exp=0",
                     if8.frame_complete);
        end
        if8.rx_active = 1'b0;
        step();
        checks++;
        if (if8.frame_complete !== 1'b1 || if8.error_code !== 3'd1) begin
            failures++;
            $display("FAIL badpid_done got=%b %0d exp=1 1",
                     if8.frame_complete, if8.error_code);
        end
        step();
        checks++;
        if (dq8.size() !== 0 || npv8 !== 0 || nfc8 !== 1) begin
            failures++;
            $display("FAIL badpid_counts got=%0d %0d %0d exp=0 0 1",
                     dq8.size(), npv8, nfc8);
        end
    endtask

    task automatic test_short();
        clr_mon();
        if8.rx_active = 1'b1;
        step();
        if8.rx_active = 1'b0;
        step();
        checks++;
        if (if8.error_code !== 3'd5 || if8.frame_complete !== 1'b1
            || if8.byte_count !== 0) begin
            failures++;
            $display("FAIL short got=%0d %b %0d exp=5 1 0",
                     if8.error_code, if8.frame_complete,
                     if8.byte_count);
        end
        step();
    endtask

    task automatic test_rx_error();
        clr_mon();
        if8.rx_active = 1'b1;
        step();
        beat8(8'h5A);
        beat8(8'h01);
        if8.rx_error = 1'b1;
        beat8(8'h02);
        if8.rx_error = 1'b0;
        checks++;
        if (if8.error_code !== 3'd2 || if8.byte_count !== 1
            || if8.data_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rxerr got=%0d %0d %b exp=2 1 0",
                     if8.error_code, if8.byte_count,
                     if8.data_out_valid);
        end
        beat8(8'h03);
        repeat (3) step();
        checks++;
        if (if8.frame_complete !== 1'b0 || if8.error_flag !== 1'b1) begin
            failures++;
            $display("FAIL rxerr_drain got=%b %b exp=0 1",
                     if8.frame_complete, if8.error_flag);
        end
        if8.rx_active = 1'b0;
        step();
        checks++;
        if (if8.frame_complete !== 1'b1) begin
            failures++;
            $display("FAIL rxerr_done got=%b exp=1",
                     if8.frame_complete);
        end
        step();
        checks++;
        if (dq8.size() !== 1 || if8.pid !== 4'hA) begin
            failures++;
            $display("FAIL rxerr_q got=%0d %h exp=1 a",
                     dq8.size(), if8.pid);
        end
    endtask

    task automatic test_timeout();
        clr_mon();
        if8.rx_active = 1'b1;
        step();
        beat8(8'h5A);
        repeat (10) step();
        beat8(8'h44);
        repeat (15) step();
        checks++;
        if (if8.error_code !== 3'd0) begin
            failures++;
            $display("FAIL gap15 got=%0d exp=0", if8.error_code);
        end
        step();
        checks++;
        if (if8.error_code !== 3'd4 || if8.error_flag !== 1'b1) begin
            failures++;
            $display("FAIL gap16 got=%0d %b exp=4 1",
                     if8.error_code, if8.error_flag);
        end
        beat8(8'h45);
        repeat (2) step();
        checks++;
        if (if8.frame_complete !== 1'b0 || if8.byte_count !== 1) begin
            failures++;
            $display("FAIL gap_drain got=%b %0d exp=0 1",
                     if8.frame_complete, if8.byte_count);
        end
        if8.rx_active = 1'b0;
        step();
        checks++;
        if (if8.frame_complete !== 1'b1 || if8.error_code !== 3'd4) begin
            failures++;
            $display("FAIL gap_done got=%b %0d exp=1 4",
                     if8.frame_complete, if8.error_code);
        end
        step();
    endtask

    task automatic test_overflow16();
        clr_mon();
        if16.rx_active = 1'b1;
        step();
        beat16(16'h772D, 1'b1);
        checks++;
        if (if16.pid_valid !== 1'b1 || if16.pid !== 4'hD
            || if16.data_out_valid !== 1'b1
            || if16.data_out_be !== 2'b10 || if16.byte_count !== 1) begin
            failures++;
            $display("FAIL w16_pid got=%b %h %b %b %0d exp=1 d 1 10 1",
                     if16.pid_valid, if16.pid, if16.data_out_valid,
                     if16.data_out_be, if16.byte_count);
        end
        beat16(16'h2211, 1'b1);
        checks++;
        if (if16.data_out_be !== 2'b11 || if16.byte_count !== 3
            || if16.data_out !== 16'h2211) begin
            failures++;
            $display("FAIL w16_beat got=%b %0d %h exp=11 3 2211",
                     if16.data_out_be, if16.byte_count, if16.data_out);
        end
        beat16(16'h4433, 1'b1);
        checks++;
        if (if16.error_code !== 3'd3 || if16.byte_count !== 3
            || if16.data_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL w16_ovf got=%0d %0d %b exp=3 3 0",
                     if16.error_code, if16.byte_count,
                     if16.data_out_valid);
        end
        if16.rx_active = 1'b0;
        step();
        step();
        checks++;
        if (dq16.size() !== 2 || nfc16 !== 1) begin
            failures++;
            $display("FAIL w16_counts got=%0d %0d exp=2 1",
                     dq16.size(), nfc16);
        end else begin
            checks++;
            if (be16[0] !== 2'b10 || be16[1] !== 2'b11
                || dq16[0] !== 16'h772D) begin
                failures++;
                $display("FAIL w16_be got=%b %b %h exp=10 11 772d",
                         be16[0], be16[1], dq16[0]);
            end
        end
    endtask

    task automatic test_max_exact16();
        clr_mon();
        if16.rx_active = 1'b1;
        step();
        beat16(16'h002D, 1'b0);
        checks++;
        if (if16.pid_valid !== 1'b1 || if16.data_out_valid !== 1'b0
            || if16.error_code !== 3'd0 || if16.byte_count !== 0) begin
            failures++;
            $display("FAIL w16_pidonly got=%b %b %0d %0d exp=1 0 0 0",
                     if16.pid_valid, if16.data_out_valid,
                     if16.error_code, if16.byte_count);
        end
        beat16(16'h2211, 1'b1);
        beat16(16'h4433, 1'b1);
        checks++;
        if (if16.error_code !== 3'd0 || if16.byte_count !== 4
            || if16.data_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL w16_exact got=%0d %0d %b exp=0 4 1",
                     if16.error_code, if16.byte_count,
                     if16.data_out_valid);
        end
        beat16(16'h0055, 1'b0);
        checks++;
        if (if16.error_code !== 3'd3 || if16.byte_count !== 4) begin
            failures++;
            $display("FAIL w16_over1 got=%0d %0d exp=3 4",
                     if16.error_code, if16.byte_count);
        end
        if16.rx_active = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_behaviour();
        logic [32:0] o8;
        int          fc0;
        clr_mon();
        nRST = 1'b0;
        if8.rx_active = 1'b1;
        step();
        nRST = 1'b1;
        step();
        beat8(8'hC3);
        step();
        checks++;
        if (if8.pid_valid !== 1'b0 || npv8 !== 0) begin
            failures++;
            $display("FAIL rel_active got=%b %0d exp=0 0",
                     if8.pid_valid, npv8);
        end
        if8.rx_active = 1'b0;
        step();
        if8.rx_active = 1'b1;
        step();
        beat8(8'hC3);
        checks++;
        if (if8.pid_valid !== 1'b1) begin
            failures++;
            $display("FAIL rel_toggle got=%b exp=1", if8.pid_valid);
        end
        beat8(8'h11);
        checks++;
        if (if8.data_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=1", if8.data_out_valid);
        end
        dq8.delete();
        fc0  = nfc8;
        nRST = 1'b0;
        #1;
        o8 = {if8.pid, if8.pid_valid, if8.data_out,
              if8.data_out_valid, if8.data_out_be, if8.byte_count,
              if8.frame_complete, if8.error_flag, if8.error_code};
        checks++;
        if (o8 !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", o8);
        end
        beat8(8'h22);
        step();
        nRST = 1'b1;
        step();
        if8.rx_active = 1'b0;
        step();
        step();
        checks++;
        if (dq8.size() !== 0 || nfc8 !== fc0) begin
            failures++;
            $display("FAIL mid_abort got=%0d %0d exp=0 %0d",
                     dq8.size(), nfc8, fc0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_good_frame();
        test_bad_pid();
        test_short();
        test_rx_error();
        test_timeout();
        test_overflow16();
        test_max_exact16();
        test_reset_behaviour();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
